tdc_hw_accum: RTL and testbench

Multi-channel post-processor for TDC Hamming-weight samples.
Each channel accumulates 2^LOG2_WIN valid samples into a sum, a mean and an optional min/max.
A round-robin arbiter presents completed results on a single valid/ready port.
It sits between N_CH tdc_top instances and the readout logic, replacing direct per-sample pin output.

---
 rtl/tdc_pkg.sv | 34 +++
 rtl/tdc_hw_accum_ch.sv | 143 ++++++++++++++
 rtl/tdc_hw_accum.sv | 162 ++++++++++++++++
 tb/tb_tdc_hw_accum.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and helpers for the TDC Hamming-weight accumulator.
// The tdc_res_t container is sized for the widest supported configuration
// (HW_W up to HW_W_MAX, LOG2_WIN up to LOG2_WIN_MAX); narrower builds
// zero-extend into it.
package tdc_pkg;

  localparam int unsigned HW_W_DEF     = 7;
  localparam int unsigned HW_W_MAX     = 16;
  localparam int unsigned LOG2_WIN_MAX = 8;
  localparam int unsigned SUM_W_MAX    = HW_W_MAX + LOG2_WIN_MAX;

  // Window sum width: holds 2^log2_win * (2^hw_w - 1) without overflow.
  function automatic int unsigned sum_width(input int unsigned hw_w,
                                            input int unsigned log2_win);
    return hw_w + log2_win;
  endfunction

  // Samples per accumulation window.
  function automatic int unsigned win_len(input int unsigned log2_win);
    return 32'd1 << log2_win;
  endfunction

  typedef enum logic [0:0] {
    StIdle,
    StPresent
  } out_state_e;

  typedef struct packed {
    logic [SUM_W_MAX-1:0] sum;
    logic [HW_W_MAX-1:0]  min;
    logic [HW_W_MAX-1:0]  max;
  } tdc_res_t;

endpackage

// File: rtl/tdc_hw_accum_ch.sv
// Per-channel window accumulator with a single-entry holding register.
// A completed window lands in the holding register and raises pend_o; if the
// previous result is still pending and not taken this cycle, the new result is
// dropped and the sticky ovf_o flag sets.
// Optional min/max tracking: TDC_ACCUM_MINMAX_EN.
module tdc_hw_acc_ch
  import tdc_pkg::*;
#(
  parameter int unsigned HW_W     = HW_W_DEF,
  parameter int unsigned LOG2_WIN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            clear_i,
  input  logic [HW_W-1:0] hw_i,
  input  logic            val_i,
  input  logic            take_i,
  output tdc_res_t        hold_o,
  output logic            pend_o,
  output logic            ovf_o
);

  localparam int unsigned SumW = sum_width(HW_W, LOG2_WIN);
  localparam logic [LOG2_WIN-1:0] LastCnt = LOG2_WIN'(win_len(LOG2_WIN) - 1);

  logic [SumW-1:0]     sum_q, sum_d, sum_new;
  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [SumW-1:0]     hold_sum_q, hold_sum_d;
  logic                pend_q, pend_d;
  logic                ovf_q, ovf_d;
  logic                accept, last, load_hold;

  // Sample acceptance, window completion and holding-register load decision.
  always_comb begin
    accept    = en_i & val_i & ~clear_i;
    last      = accept && (cnt_q == LastCnt);
    sum_new   = sum_q + SumW'(hw_i);
    load_hold = last && (!pend_q || take_i);
  end

  // Running sum and sample counter; both restart on completion or clear.
  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (clear_i || last) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      sum_d = sum_new;
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Holding register, pend and sticky overflow; a take frees the slot in the
  // same cycle a new result may reload it.
  always_comb begin
    hold_sum_d = hold_sum_q;
    pend_d     = pend_q;
    ovf_d      = ovf_q;
    if (clear_i) begin
      pend_d = 1'b0;
      ovf_d  = 1'b0;
    end else begin
      if (take_i) pend_d = 1'b0;
      if (load_hold) begin
        hold_sum_d = sum_new;
        pend_d     = 1'b1;
      end else if (last) begin
        ovf_d = 1'b1;
      end
    end
  end

  // Sum/count/holding state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      cnt_q      <= '0;
      hold_sum_q <= '0;
      pend_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      hold_sum_q <= hold_sum_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef TDC_ACCUM_MINMAX_EN
  logic [HW_W-1:0] min_q, min_d, max_q, max_d, min_new, max_new;
  logic [HW_W-1:0] hold_min_q, hold_min_d, hold_max_q, hold_max_d;

  // First sample of a window loads min/max directly.
  always_comb begin
    min_new    = ((cnt_q == '0) || (hw_i < min_q)) ? hw_i : min_q;
    max_new    = ((cnt_q == '0) || (hw_i > max_q)) ? hw_i : max_q;
    min_d      = min_q;
    max_d      = max_q;
    hold_min_d = hold_min_q;
    hold_max_d = hold_max_q;
    if (accept && !last) begin
      min_d = min_new;
      max_d = max_new;
    end
    if (load_hold) begin
      hold_min_d = min_new;
      hold_max_d = max_new;
    end
  end

  // Min/max running and holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q      <= '0;
      max_q      <= '0;
      hold_min_q <= '0;
      hold_max_q <= '0;
    end else begin
      min_q      <= min_d;
      max_q      <= max_d;
      hold_min_q <= hold_min_d;
      hold_max_q <= hold_max_d;
    end
  end
`endif

  // Pack the held result into the shared container.
  always_comb begin
    hold_o     = '0;
    hold_o.sum = SUM_W_MAX'(hold_sum_q);
`ifdef TDC_ACCUM_MINMAX_EN
    hold_o.min = HW_W_MAX'(hold_min_q);
    hold_o.max = HW_W_MAX'(hold_max_q);
`endif
  end

  assign pend_o = pend_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/tdc_hw_accum.sv
// Multi-channel TDC Hamming-weight post-processor: per-channel window
// accumulators feeding a round-robin arbiter and a valid/ready result port.
// Optional min/max tracking: TDC_ACCUM_MINMAX_EN.
module tdc_hw_accum
  import tdc_pkg::*;
#(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned HW_W     = HW_W_DEF,
  parameter int unsigned LOG2_WIN = 4,
  localparam int unsigned ChW     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int unsigned SumW    = HW_W + LOG2_WIN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clear,
  input  logic [N_CH*HW_W-1:0] hw_in,
  input  logic [N_CH-1:0]      val_in,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ChW-1:0]       res_ch,
  output logic [SumW-1:0]      res_sum,
  output logic [HW_W-1:0]      res_mean,
  output logic [HW_W-1:0]      res_min,
  output logic [HW_W-1:0]      res_max,
  output logic [N_CH-1:0]      ovf
);

  tdc_res_t        hold [N_CH];
  logic [N_CH-1:0] pend;
  logic [N_CH-1:0] take;

  for (genvar c = 0; c < N_CH; c++) begin : gen_ch
    tdc_hw_acc_ch #(
      .HW_W    (HW_W),
      .LOG2_WIN(LOG2_WIN)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en),
      .clear_i(clear),
      .hw_i   (hw_in[c*HW_W +: HW_W]),
      .val_i  (val_in[c]),
      .take_i (take[c]),
      .hold_o (hold[c]),
      .pend_o (pend[c]),
      .ovf_o  (ovf[c])
    );
  end

  out_state_e     state_q, state_d;
  logic [ChW-1:0] ptr_q, ptr_d;
  logic           valid_q, valid_d;
  logic [ChW-1:0] ch_q, ch_d;
  logic [SumW-1:0] sum_q, sum_d;
  logic           arb_found;
  logic [ChW-1:0] arb_sel, arb_idx;
  logic           unused_hold;

  // Round-robin pick: first pending channel at or after ptr, cyclically.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = '0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      arb_idx = ChW'((32'(ptr_q) + i) % N_CH);
      if (!arb_found && pend[arb_idx]) begin
        arb_found = 1'b1;
        arb_sel   = arb_idx;
      end
    end
  end

  // Output FSM: IDLE loads a pending result, PRESENT holds it until accepted.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    valid_d = valid_q;
    ch_d    = ch_q;
    sum_d   = sum_q;
    take    = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          take[arb_sel] = 1'b1;
          valid_d       = 1'b1;
          ch_d          = arb_sel;
          sum_d         = hold[arb_sel].sum[SumW-1:0];
          state_d       = StPresent;
        end
      end
      StPresent: begin
        if (res_ready) begin
          valid_d = 1'b0;
          ptr_d   = (32'(ch_q) == N_CH - 1) ? '0 : ch_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM, pointer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      ch_q    <= ch_d;
      sum_q   <= sum_d;
    end
  end

`ifdef TDC_ACCUM_MINMAX_EN
  logic [HW_W-1:0] min_q, min_d, max_q, max_d;

  // Min/max output registers load alongside the sum.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (state_q == StIdle && arb_found) begin
      min_d = hold[arb_sel].min[HW_W-1:0];
      max_d = hold[arb_sel].max[HW_W-1:0];
    end
  end

  // Min/max output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign res_min = min_q;
  assign res_max = max_q;
`else
  assign res_min = '0;
  assign res_max = '0;
`endif

  // Upper container bits are zero for narrow builds; fold them away.
  always_comb begin
    unused_hold = 1'b0;
    for (int c = 0; c < N_CH; c++) unused_hold = unused_hold ^ (^hold[c]);
  end

  assign res_valid = valid_q;
  assign res_ch    = ch_q;
  assign res_sum   = sum_q;
  assign res_mean  = sum_q[SumW-1:LOG2_WIN];

endmodule

// File: tb/tb_tdc_hw_accum.sv
// Directed bench for tdc_hw_accum (N_CH=2, HW_W=7, LOG2_WIN=2).
// Expected min/max follow TDC_ACCUM_MINMAX_EN: real values when defined, 0 otherwise.
module tb_tdc_hw_accum;

`ifdef TDC_ACCUM_MINMAX_EN
  localparam bit MM = 1'b1;
`else
  localparam bit MM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        clear = 1'b0;
  logic [13:0] hw_in = '0;
  logic [1:0]  val_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic        res_ch;
  logic [8:0]  res_sum;
  logic [6:0]  res_mean, res_min, res_max;
  logic [1:0]  ovf;

  int checks = 0;
  int errors = 0;

  tdc_hw_accum #(
    .N_CH    (2),
    .HW_W    (7),
    .LOG2_WIN(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (clear),
    .hw_in    (hw_in),
    .val_in   (val_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_ch   (res_ch),
    .res_sum  (res_sum),
    .res_mean (res_mean),
    .res_min  (res_min),
    .res_max  (res_max),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] mm(input logic [6:0] v);
    return MM ? v : 7'd0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [6:0] h0, input logic [6:0] h1, input logic [1:0] v);
    hw_in  = {h1, h0};
    val_in = v;
    cyc();
    val_in = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum, res_mean, res_min, res_max, ovf} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%0d ch=%0d sum=%0d mean=%0d min=%0d max=%0d ovf=%0d want all 0",
               res_valid, res_ch, res_sum, res_mean, res_min, res_max, ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    feed(7'd10, 7'd0, 2'b01);
    feed(7'd20, 7'd0, 2'b01);
    feed(7'd30, 7'd0, 2'b01);
    feed(7'd40, 7'd0, 2'b01);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_valid got %0d want 0", res_valid);
    end
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum, res_mean, res_min, res_max} !==
        {1'b1, 1'b0, 9'd100, 7'd25, mm(7'd10), mm(7'd40)}) begin
      errors++;
      $display("FAIL single_result got v=%0d ch=%0d sum=%0d mean=%0d min=%0d max=%0d want v=1 ch=0 sum=100 mean=25 min=%0d max=%0d",
               res_valid, res_ch, res_sum, res_mean, res_min, res_max, mm(7'd10), mm(7'd40));
    end
    cyc();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_after_handshake got valid=%0d want 0", res_valid);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) feed(7'd1, 7'd127, 2'b11);
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum, res_mean, res_min, res_max} !==
        {1'b1, 1'b0, 9'd4, 7'd1, mm(7'd1), mm(7'd1)}) begin
      errors++;
      $display("FAIL simul_first got v=%0d ch=%0d sum=%0d mean=%0d min=%0d max=%0d want v=1 ch=0 sum=4 mean=1",
               res_valid, res_ch, res_sum, res_mean, res_min, res_max);
    end
    cyc();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL simul_gap got valid=%0d want 0", res_valid);
    end
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum, res_mean, res_min, res_max} !==
        {1'b1, 1'b1, 9'd508, 7'd127, mm(7'd127), mm(7'd127)}) begin
      errors++;
      $display("FAIL simul_second got v=%0d ch=%0d sum=%0d mean=%0d min=%0d max=%0d want v=1 ch=1 sum=508 mean=127",
               res_valid, res_ch, res_sum, res_mean, res_min, res_max);
    end
    cyc();
    for (int i = 0; i < 4; i++) feed(7'd2, 7'd3, 2'b11);
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum} !== {1'b1, 1'b0, 9'd8}) begin
      errors++;
      $display("FAIL simul_again_first got v=%0d ch=%0d sum=%0d want v=1 ch=0 sum=8",
               res_valid, res_ch, res_sum);
    end
    cyc();
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum} !== {1'b1, 1'b1, 9'd12}) begin
      errors++;
      $display("FAIL simul_again_second got v=%0d ch=%0d sum=%0d want v=1 ch=1 sum=12",
               res_valid, res_ch, res_sum);
    end
    cyc();
  endtask

  task automatic test_backpressure();
    res_ready = 1'b0;
    for (int i = 1; i <= 8; i++) feed(7'(i), 7'd0, 2'b01);
    checks++;
    if ({res_valid, res_sum, ovf} !== {1'b1, 9'd10, 2'b00}) begin
      errors++;
      $display("FAIL bp_mid got v=%0d sum=%0d ovf=%0d want v=1 sum=10 ovf=0", res_valid, res_sum, ovf);
    end
    for (int i = 0; i < 4; i++) feed(7'd9, 7'd0, 2'b01);
    checks++;
    if ({res_valid, res_ch, res_sum, res_min, res_max, ovf} !==
        {1'b1, 1'b0, 9'd10, mm(7'd1), mm(7'd4), 2'b01}) begin
      errors++;
      $display("FAIL bp_stalled got v=%0d ch=%0d sum=%0d min=%0d max=%0d ovf=%0d want v=1 ch=0 sum=10 ovf=1",
               res_valid, res_ch, res_sum, res_min, res_max, ovf);
    end
    res_ready = 1'b1;
    cyc();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_first_taken got valid=%0d want 0", res_valid);
    end
    cyc();
    checks++;
    if ({res_valid, res_sum, res_mean, res_min, res_max} !==
        {1'b1, 9'd26, 7'd6, mm(7'd5), mm(7'd8)}) begin
      errors++;
      $display("FAIL bp_second got v=%0d sum=%0d mean=%0d min=%0d max=%0d want v=1 sum=26 mean=6",
               res_valid, res_sum, res_mean, res_min, res_max);
    end
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_no_third cycle %0d got valid=%0d want 0", i, res_valid);
      end
    end
    checks++;
    if (ovf !== 2'b01) begin
      errors++;
      $display("FAIL bp_ovf_sticky got %0d want 1", ovf);
    end
  endtask

  task automatic test_clear();
    feed(7'd0, 7'd5, 2'b10);
    feed(7'd0, 7'd5, 2'b10);
    clear = 1'b1;
    feed(7'd0, 7'd9, 2'b10);
    clear = 1'b0;
    checks++;
    if (ovf !== 2'b00) begin
      errors++;
      $display("FAIL clear_ovf got %0d want 0", ovf);
    end
    for (int i = 0; i < 4; i++) feed(7'd0, 7'd1, 2'b10);
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum, res_mean, res_min, res_max, ovf} !==
        {1'b1, 1'b1, 9'd4, 7'd1, mm(7'd1), mm(7'd1), 2'b00}) begin
      errors++;
      $display("FAIL clear_result got v=%0d ch=%0d sum=%0d mean=%0d min=%0d max=%0d ovf=%0d want v=1 ch=1 sum=4 mean=1 ovf=0",
               res_valid, res_ch, res_sum, res_mean, res_min, res_max, ovf);
    end
    cyc();
  endtask

  task automatic test_enable();
    feed(7'd7, 7'd0, 2'b01);
    feed(7'd7, 7'd0, 2'b01);
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      feed(7'd60, 7'd50, 2'b11);
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL en_low_valid cycle %0d got %0d want 0", i, res_valid);
      end
    end
    en = 1'b1;
    feed(7'd1, 7'd0, 2'b01);
    feed(7'd1, 7'd0, 2'b01);
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum, res_mean, res_min, res_max} !==
        {1'b1, 1'b0, 9'd16, 7'd4, mm(7'd1), mm(7'd7)}) begin
      errors++;
      $display("FAIL en_resume got v=%0d ch=%0d sum=%0d mean=%0d min=%0d max=%0d want v=1 ch=0 sum=16 mean=4",
               res_valid, res_ch, res_sum, res_mean, res_min, res_max);
    end
    cyc();
  endtask

  task automatic test_reset_in_present();
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) feed(7'd0, 7'd2, 2'b10);
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum} !== {1'b1, 1'b1, 9'd8}) begin
      errors++;
      $display("FAIL rstp_present got v=%0d ch=%0d sum=%0d want v=1 ch=1 sum=8", res_valid, res_ch, res_sum);
    end
    rst = 1'b1;
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum, res_mean, res_min, res_max, ovf} !== 39'd0) begin
      errors++;
      $display("FAIL rstp_cleared got v=%0d ch=%0d sum=%0d mean=%0d min=%0d max=%0d ovf=%0d want all 0",
               res_valid, res_ch, res_sum, res_mean, res_min, res_max, ovf);
    end
    rst = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) feed(7'd10, 7'd20, 2'b11);
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum, res_mean} !== {1'b1, 1'b0, 9'd40, 7'd10}) begin
      errors++;
      $display("FAIL rstp_ch0_first got v=%0d ch=%0d sum=%0d mean=%0d want v=1 ch=0 sum=40 mean=10",
               res_valid, res_ch, res_sum, res_mean);
    end
    cyc();
    cyc();
    checks++;
    if ({res_valid, res_ch, res_sum, res_mean} !== {1'b1, 1'b1, 9'd80, 7'd20}) begin
      errors++;
      $display("FAIL rstp_ch1_next got v=%0d ch=%0d sum=%0d mean=%0d want v=1 ch=1 sum=80 mean=20",
               res_valid, res_ch, res_sum, res_mean);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_clear();
    test_enable();
    test_reset_in_present();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
